// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data-memory responder: LSU operator codes, access
// sizes, responder FSM states and the operator decode helpers.
package data_mem_responder_pkg;

    localparam int DMEM_MAX_LATENCY = 15;
    localparam int DMEM_CNT_W       = $clog2(DMEM_MAX_LATENCY + 1);

    typedef enum logic [2:0] {
        LSU_LB,
        LSU_LBU,
        LSU_LH,
        LSU_LHU,
        LSU_LW,
        LSU_SB,
        LSU_SH,
        LSU_SW
    } load_store_func_code;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DONE
    } dmem_state_e;

    function automatic logic is_store(input load_store_func_code op);
        return (op == LSU_SB) || (op == LSU_SH) || (op == LSU_SW);
    endfunction

    function automatic mem_size_e access_size(input load_store_func_code op);
        case (op)
            LSU_LB, LSU_LBU, LSU_SB: return SZ_BYTE;
            LSU_LH, LSU_LHU, LSU_SH: return SZ_HALF;
            default:                 return SZ_WORD;
        endcase
    endfunction

endpackage

// File: rtl/data_mem_responder_lane_align.sv
// Byte-lane steering for one 32-bit word: store byte enables and merge,
// load right-alignment with zero fill, and the alignment check.
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  mem_size_e   i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_rword,
    output logic [3:0]  o_byte_en,
    output logic [31:0] o_wdata_merged,
    output logic [31:0] o_load_data,
    output logic        o_misaligned
);
    logic [31:0] w_wdata_rep;
    logic [15:0] w_rshift;

    always_comb begin
        o_byte_en      = 4'b1111;
        w_wdata_rep    = i_wdata;
        o_load_data    = i_rword;
        o_misaligned   = 1'b0;
        o_wdata_merged = i_rword;
        w_rshift       = 16'(i_rword >> {i_addr_lo, 3'b000});

        case (i_size)
            SZ_BYTE: begin
                o_byte_en   = 4'b0001 << i_addr_lo;
                w_wdata_rep = {4{i_wdata[7:0]}};
                o_load_data = {24'h000000, w_rshift[7:0]};
            end
            SZ_HALF: begin
                o_byte_en    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                w_wdata_rep  = {2{i_wdata[15:0]}};
                o_load_data  = {16'h0000, w_rshift};
                o_misaligned = i_addr_lo[0];
            end
            default: begin
                o_misaligned = |i_addr_lo;
            end
        endcase

        // Replicated write data lands only in enabled lanes; the rest keep the old word.
        for (int i = 0; i < 4; i++) begin
            if (o_byte_en[i]) begin
                o_wdata_merged[8*i +: 8] = w_wdata_rep[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one LSU access at a time, waits LATENCY
// enabled cycles, then returns a single-cycle grant with load data or error.
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int          DEPTH     = 256,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0200,
    parameter int          LATENCY   = 2
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                mem_en,
    input  logic                data_req_ip,
    input  logic [31:0]         data_addr_ip,
    input  load_store_func_code lsu_operator_ip,
    input  logic [31:0]         wdata_ip,
    output logic                mem_gnt_op,
    output logic                load_valid_op,
    output logic [31:0]         load_data_op,
    output logic                err_op,
    output logic                busy_op
);
    localparam int                    IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DMEM_CNT_W-1:0] CNT_LOAD = DMEM_CNT_W'(LATENCY - 1);

    dmem_state_e         r_state;
    logic [DMEM_CNT_W-1:0] r_count;
    logic [31:0]         r_addr;
    load_store_func_code r_op;
    logic [31:0]         r_wdata;
    logic                r_gnt;
    logic                r_load_valid;
    logic [31:0]         r_load_data;
    logic                r_err;
    logic                r_busy;
    logic [31:0]         r_mem [DEPTH];

    logic [31:0]         w_cur_addr;
    load_store_func_code w_cur_op;
    logic [31:0]         w_cur_wdata;
    logic [29:0]         w_word_off;
    logic [IDX_W-1:0]    w_idx;
    logic                w_in_range;
    mem_size_e           w_size;
    logic [31:0]         w_rword;
    logic [3:0]          w_byte_en;
    logic [31:0]         w_merged;
    logic [31:0]         w_load_data;
    logic                w_misaligned;
    logic                w_error;
    logic                w_done_valid;
    logic [31:0]         w_done_data;
    logic                w_we;

    // In IDLE the decode looks at the live request so a LATENCY of 1 can
    // enter DONE on the accepting edge; otherwise it uses the latched copy.
    assign w_cur_addr  = (r_state == ST_IDLE) ? data_addr_ip    : r_addr;
    assign w_cur_op    = (r_state == ST_IDLE) ? lsu_operator_ip : r_op;
    assign w_cur_wdata = (r_state == ST_IDLE) ? wdata_ip        : r_wdata;

    assign w_word_off   = 30'((w_cur_addr - BASE_ADDR) >> 2);
    assign w_in_range   = (w_cur_addr >= BASE_ADDR) && ({2'b00, w_word_off} < 32'(DEPTH));
    assign w_idx        = w_word_off[IDX_W-1:0];
    assign w_size       = access_size(w_cur_op);
    assign w_rword      = r_mem[w_idx];
    assign w_error      = !w_in_range || w_misaligned;
    assign w_done_valid = !w_error && !is_store(w_cur_op);
    assign w_done_data  = w_done_valid ? w_load_data : 32'h0000_0000;
    assign w_we         = !reset && mem_en && (r_state == ST_DONE) && is_store(r_op) && !r_err;

    dmem_lane_align u_lane_align (
        .i_size         (w_size),
        .i_addr_lo      (w_cur_addr[1:0]),
        .i_wdata        (w_cur_wdata),
        .i_rword        (w_rword),
        .o_byte_en      (w_byte_en),
        .o_wdata_merged (w_merged),
        .o_load_data    (w_load_data),
        .o_misaligned   (w_misaligned)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_count      <= '0;
            r_addr       <= '0;
            r_op         <= LSU_LB;
            r_wdata      <= '0;
            r_gnt        <= 1'b0;
            r_load_valid <= 1'b0;
            r_load_data  <= '0;
            r_err        <= 1'b0;
            r_busy       <= 1'b0;
        end else if (mem_en) begin
            case (r_state)
                ST_IDLE: begin
                    if (data_req_ip) begin
                        r_addr  <= data_addr_ip;
                        r_op    <= lsu_operator_ip;
                        r_wdata <= wdata_ip;
                        r_busy  <= 1'b1;
                        if (LATENCY <= 1) begin
                            r_state      <= ST_DONE;
                            r_count      <= '0;
                            r_gnt        <= 1'b1;
                            r_err        <= w_error;
                            r_load_valid <= w_done_valid;
                            r_load_data  <= w_done_data;
                        end else begin
                            r_state <= ST_WAIT;
                            r_count <= CNT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    r_count <= r_count - 1'b1;
                    if (r_count <= 1) begin
                        r_state      <= ST_DONE;
                        r_gnt        <= 1'b1;
                        r_err        <= w_error;
                        r_load_valid <= w_done_valid;
                        r_load_data  <= w_done_data;
                    end
                end
                ST_DONE: begin
                    r_state      <= ST_IDLE;
                    r_busy       <= 1'b0;
                    r_gnt        <= 1'b0;
                    r_err        <= 1'b0;
                    r_load_valid <= 1'b0;
                    r_load_data  <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The array is deliberately not reset; stores commit on the DONE cycle.
    always_ff @(posedge clock) begin
        if (w_we) begin
            r_mem[w_idx] <= w_merged;
        end
    end

    assign mem_gnt_op    = r_gnt;
    assign load_valid_op = r_load_valid;
    assign load_data_op  = r_load_data;
    assign err_op        = r_err;
    assign busy_op       = r_busy;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder with a byte-level memory model that
// predicts every output on every cycle, plus literal checks on key results.
module tb_data_mem_responder;
    import data_mem_responder_pkg::*;

    localparam int          DEPTH = 256;
    localparam logic [31:0] BASE  = 32'h0000_0200;
    localparam int          LAT   = 2;

    logic                clock = 1'b0;
    logic                reset;
    logic                mem_en;
    logic                data_req_ip;
    logic [31:0]         data_addr_ip;
    load_store_func_code lsu_operator_ip;
    logic [31:0]         wdata_ip;
    logic                mem_gnt_op;
    logic                load_valid_op;
    logic [31:0]         load_data_op;
    logic                err_op;
    logic                busy_op;

    int checks   = 0;
    int failures = 0;

    data_mem_responder #(
        .DEPTH     (DEPTH),
        .BASE_ADDR (BASE),
        .LATENCY   (LAT)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .mem_en          (mem_en),
        .data_req_ip     (data_req_ip),
        .data_addr_ip    (data_addr_ip),
        .lsu_operator_ip (lsu_operator_ip),
        .wdata_ip        (wdata_ip),
        .mem_gnt_op      (mem_gnt_op),
        .load_valid_op   (load_valid_op),
        .load_data_op    (load_data_op),
        .err_op          (err_op),
        .busy_op         (busy_op)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: memory as bytes, an access completes after LAT enabled edges.
    logic [7:0]          mByte [4*DEPTH];
    bit                  mBusy  = 1'b0;
    int                  mTicks = 0;
    load_store_func_code mOp;
    logic [31:0]         mAddr;
    logic [31:0]         mWdata;

    function automatic int modelSize(input load_store_func_code op);
        if (op == LSU_LB || op == LSU_LBU || op == LSU_SB) return 1;
        if (op == LSU_LH || op == LSU_LHU || op == LSU_SH) return 2;
        return 4;
    endfunction

    function automatic bit modelStore(input load_store_func_code op);
        return op == LSU_SB || op == LSU_SH || op == LSU_SW;
    endfunction

    function automatic bit modelErr(input logic [31:0] a, input load_store_func_code op);
        logic [31:0] off;
        if (a < BASE) return 1'b1;
        off = a - BASE;
        if ((off >> 2) >= 32'(DEPTH)) return 1'b1;
        return (a % 32'(modelSize(op))) != 32'd0;
    endfunction

    function automatic logic [31:0] modelLoad(input logic [31:0] a, input load_store_func_code op);
        logic [31:0] v;
        int o;
        v = 32'h0;
        o = int'(a - BASE);
        for (int i = 0; i < modelSize(op); i++) v[8*i +: 8] = mByte[o + i];
        return v;
    endfunction

    initial begin
        for (int i = 0; i < 4*DEPTH; i++) mByte[i] = 8'h00;
    end

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            mBusy  = 1'b0;
            mTicks = 0;
        end else if (mem_en) begin
            if (!mBusy) begin
                if (data_req_ip) begin
                    mBusy  = 1'b1;
                    mTicks = 1;
                    mOp    = lsu_operator_ip;
                    mAddr  = data_addr_ip;
                    mWdata = wdata_ip;
                end
            end else if (mTicks == LAT) begin
                if (modelStore(mOp) && !modelErr(mAddr, mOp)) begin
                    for (int i = 0; i < modelSize(mOp); i++)
                        mByte[int'(mAddr - BASE) + i] = mWdata[8*i +: 8];
                end
                mBusy = 1'b0;
            end else begin
                mTicks++;
            end
        end
    end

    // Per-cycle comparison of every output against the model.
    logic        eGnt, eErr, eValid;
    logic [31:0] eData;
    always @(negedge clock) begin
        eGnt   = mBusy && (mTicks == LAT);
        eErr   = eGnt && modelErr(mAddr, mOp);
        eValid = eGnt && !eErr && !modelStore(mOp);
        eData  = eValid ? modelLoad(mAddr, mOp) : 32'h0;
        checkOutput("cyc_busy",  32'(busy_op),       32'(mBusy));
        checkOutput("cyc_gnt",   32'(mem_gnt_op),    32'(eGnt));
        checkOutput("cyc_err",   32'(err_op),        32'(eErr));
        checkOutput("cyc_valid", 32'(load_valid_op), 32'(eValid));
        checkOutput("cyc_data",  load_data_op,       eData);
    end

    logic [31:0] rd;
    logic        re;
    logic        rv;
    int          lat;

    // One access from an idle DUT; optional mem_en drop of dropLen cycles
    // starting dropAt negedges after the accepting edge.
    task automatic applyStimulus(input load_store_func_code op, input logic [31:0] addr,
                                 input logic [31:0] wd, input int dropAt, input int dropLen,
                                 output logic [31:0] data, output logic err,
                                 output logic valid, output int latency);
        @(negedge clock);
        data_req_ip     = 1'b1;
        lsu_operator_ip = op;
        data_addr_ip    = addr;
        wdata_ip        = wd;
        latency = -1;
        data    = 32'h0;
        err     = 1'b0;
        valid   = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (dropAt != 0 && k == dropAt) mem_en = 1'b0;
            if (dropAt != 0 && k == dropAt + dropLen) mem_en = 1'b1;
            if (mem_gnt_op) begin
                latency = k;
                data    = load_data_op;
                err     = err_op;
                valid   = load_valid_op;
                break;
            end
        end
        data_req_ip = 1'b0;
        mem_en      = 1'b1;
        checkOutput("grant_seen", 32'(latency > 0), 32'd1);
    endtask

    int grantAt [3];
    int nGrant;
    int idleCnt;

    initial begin
        reset           = 1'b1;
        mem_en          = 1'b1;
        data_req_ip     = 1'b0;
        data_addr_ip    = 32'h0;
        lsu_operator_ip = LSU_LW;
        wdata_ip        = 32'h0;
        repeat (2) @(negedge clock);
        checkOutput("reset_busy", 32'(busy_op),    32'd0);
        checkOutput("reset_gnt",  32'(mem_gnt_op), 32'd0);
        checkOutput("reset_data", load_data_op,    32'd0);
        reset = 1'b0;

        applyStimulus(LSU_SW, 32'h200, 32'hDEADBEEF, 0, 0, rd, re, rv, lat);
        checkOutput("sw200_lat", 32'(lat), 32'd2);
        checkOutput("sw200_err", 32'(re),  32'd0);
        applyStimulus(LSU_LW, 32'h200, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lw200_lat",   32'(lat), 32'd2);
        checkOutput("lw200_data",  rd,       32'hDEADBEEF);
        checkOutput("lw200_valid", 32'(rv),  32'd1);

        applyStimulus(LSU_SW, 32'h204, 32'h11223344, 0, 0, rd, re, rv, lat);
        applyStimulus(LSU_SB, 32'h205, 32'h000000AA, 0, 0, rd, re, rv, lat);
        applyStimulus(LSU_LBU, 32'h205, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lbu205_data", rd, 32'h000000AA);
        applyStimulus(LSU_LW, 32'h204, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lw204_data", rd, 32'h1122AA44);
        applyStimulus(LSU_LH, 32'h204, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lh204_data", rd, 32'h0000AA44);
        applyStimulus(LSU_LHU, 32'h206, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lhu206_data", rd, 32'h00001122);
        applyStimulus(LSU_LB, 32'h200, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lb200_data", rd, 32'h000000EF);

        applyStimulus(LSU_LH, 32'h203, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lh203_err",   32'(re), 32'd1);
        checkOutput("lh203_data",  rd,      32'd0);
        checkOutput("lh203_valid", 32'(rv), 32'd0);
        applyStimulus(LSU_LW, 32'h600, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lw600_err",  32'(re), 32'd1);
        checkOutput("lw600_data", rd,      32'd0);
        applyStimulus(LSU_LW, 32'h1FC, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lw1fc_err", 32'(re), 32'd1);
        applyStimulus(LSU_SW, 32'h201, 32'h0BADF00D, 0, 0, rd, re, rv, lat);
        checkOutput("sw201_err", 32'(re), 32'd1);
        applyStimulus(LSU_SW, 32'h600, 32'h55555555, 0, 0, rd, re, rv, lat);
        checkOutput("sw600_err", 32'(re), 32'd1);
        applyStimulus(LSU_LW, 32'h200, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lw200_unchanged", rd, 32'hDEADBEEF);

        // Request held high across three loads.
        @(negedge clock);
        data_req_ip     = 1'b1;
        lsu_operator_ip = LSU_LW;
        data_addr_ip    = 32'h204;
        nGrant  = 0;
        idleCnt = 0;
        for (int i = 0; i < 3; i++) grantAt[i] = 0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clock);
            if (mem_gnt_op) begin
                grantAt[nGrant] = k;
                nGrant++;
                if (nGrant == 3) break;
            end else if (nGrant > 0 && !busy_op) begin
                idleCnt++;
            end
        end
        data_req_ip = 1'b0;
        checkOutput("b2b_count", 32'(nGrant), 32'd3);
        checkOutput("b2b_first", 32'(grantAt[0]), 32'd2);
        checkOutput("b2b_gap1",  32'(grantAt[1] - grantAt[0]), 32'(LAT + 1));
        checkOutput("b2b_gap2",  32'(grantAt[2] - grantAt[1]), 32'(LAT + 1));
        checkOutput("b2b_idle",  32'(idleCnt), 32'd2);

        applyStimulus(LSU_SH, 32'h202, 32'h0000BEEF, 1, 3, rd, re, rv, lat);
        checkOutput("sh202_lat", 32'(lat), 32'd5);
        checkOutput("sh202_err", 32'(re),  32'd0);
        applyStimulus(LSU_LW, 32'h200, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lw200_after_sh", rd, 32'hBEEFBEEF);

        // Reset one cycle after an accepted store aborts it.
        applyStimulus(LSU_SW, 32'h208, 32'hCAFEF00D, 0, 0, rd, re, rv, lat);
        @(negedge clock);
        data_req_ip     = 1'b1;
        lsu_operator_ip = LSU_SW;
        data_addr_ip    = 32'h208;
        wdata_ip        = 32'h12345678;
        @(negedge clock);
        #2;
        reset       = 1'b1;
        data_req_ip = 1'b0;
        #1;
        checkOutput("abort_busy", 32'(busy_op),    32'd0);
        checkOutput("abort_gnt",  32'(mem_gnt_op), 32'd0);
        @(negedge clock);
        reset = 1'b0;
        repeat (4) @(negedge clock);
        applyStimulus(LSU_LW, 32'h208, 32'h0, 0, 0, rd, re, rv, lat);
        checkOutput("lw208_after_abort", rd, 32'hCAFEF00D);

        repeat (2) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
